l2_cache_control: RTL

//  Control FSM for the 4-way, 8-set, 128-bit-line unified L2. Sits directly upstream of the L2 datapath.

---
 rtl/lc3b_types.sv | 42 ++++
 rtl/l2_plru.sv | 13 +
 rtl/l2_cache_control.sv | 102 ++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared L2 cache types, control FSM encoding and pseudo-LRU helpers
// Exports geometry typedefs, per-way status/control structs, lc3b_l2_fsm,
// plru_victim (PLRU bits -> victim way) and plru_update (PLRU bits, accessed way -> new bits).
package lc3b_types;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [2:0]   lc3b_l2_lru;
    typedef struct packed {
        logic hit;
        logic d_out;
    } lc3b_cWay_state;
    typedef struct packed {
        lc3b_cWay_state way3;
        lc3b_cWay_state way2;
        lc3b_cWay_state way1;
        lc3b_cWay_state way0;
    } lc3b_L2_state;
    typedef struct packed {
        logic load_d;
        logic load_v;
        logic load_TD;
        logic d_in;
        logic v_in;
    } lc3b_cWay_ctl;
    typedef struct packed {
        logic         load_lru;
        lc3b_cWay_ctl way3;
        lc3b_cWay_ctl way2;
        lc3b_cWay_ctl way1;
        lc3b_cWay_ctl way0;
    } lc3b_L2_ctl;
    typedef enum logic [1:0] {L2_IDLE, L2_WRITEBACK, L2_ALLOCATE} lc3b_l2_fsm;
    // bit 2 picks the pair, bit 1 / bit 0 pick the way inside pair {0,1} / {2,3}
    function automatic logic [1:0] plru_victim(lc3b_l2_lru lru);
        return lru[2] ? (lru[0] ? 2'd3 : 2'd2) : (lru[1] ? 2'd1 : 2'd0);
    endfunction
    // point the tree away from the accessed way; the other pair's bit is untouched
    function automatic lc3b_l2_lru plru_update(lc3b_l2_lru lru, logic [1:0] way);
        return way[1] ? {1'b0, lru[1], ~way[0]} : {1'b1, ~way[0], lru[0]};
    endfunction
endpackage

// File: rtl/l2_plru.sv
// l2_plru: combinational 4-way pseudo-LRU victim selection and update
// i_lru: stored PLRU bits; i_way: accessed way; o_victim: way to replace; o_lru_next: updated bits
module l2_plru
    import lc3b_types::*;
(
    input  lc3b_l2_lru i_lru,
    input  logic [1:0] i_way,
    output logic [1:0] o_victim,
    output lc3b_l2_lru o_lru_next
);
    assign o_victim   = plru_victim(i_lru);
    assign o_lru_next = plru_update(i_lru, i_way);
endmodule

// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for the 4-way 8-set L2 (hits, clean misses, dirty-victim writeback)
// clk, rst                           : clock, synchronous active-high reset
// i_mem_read, i_mem_write            : L1 request, held until o_mem_resp (write wins if both)
// i_state, i_lru                     : per-way hit/dirty and PLRU bits of the addressed set
// o_mem_resp                         : single-cycle completion pulse, only in IDLE
// o_lru_out, o_ctl                   : new PLRU bits and per-way load/valid/dirty strobes
// o_way_sel, o_addr_sel, o_datain_sel: datapath mux selects
// o_pmem_read, o_pmem_write, i_pmem_resp : physical memory handshake
module l2_cache_control
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    output logic         o_mem_resp,
    input  lc3b_L2_state i_state,
    input  lc3b_l2_lru   i_lru,
    output lc3b_l2_lru   o_lru_out,
    output lc3b_L2_ctl   o_ctl,
    output logic [1:0]   o_way_sel,
    output logic         o_addr_sel,
    output logic         o_datain_sel,
    output logic         o_pmem_read,
    output logic         o_pmem_write,
    input  logic         i_pmem_resp
);
    lc3b_l2_fsm   r_state;
    logic [1:0]   r_victim;
    logic         r_pmem_read;
    logic         r_pmem_write;
    logic [3:0]   w_hit;
    logic [3:0]   w_dirty;
    logic [1:0]   w_hit_way;
    logic [1:0]   w_victim;
    lc3b_l2_lru   w_lru_next;
    logic         w_req;
    logic         w_hit_resp;
    logic         w_wb_done;
    logic         w_fill;
    lc3b_cWay_ctl w_way_ctl [4];
    assign w_hit     = {i_state.way3.hit, i_state.way2.hit, i_state.way1.hit, i_state.way0.hit};
    assign w_dirty   = {i_state.way3.d_out, i_state.way2.d_out, i_state.way1.d_out, i_state.way0.d_out};
    assign w_hit_way = w_hit[0] ? 2'd0 : w_hit[1] ? 2'd1 : w_hit[2] ? 2'd2 : 2'd3;
    assign w_req     = i_mem_read | i_mem_write;
    // strobes are gated by rst so a reset cycle never commits a hit or a partial fill
    assign w_hit_resp = !rst && r_state == L2_IDLE && w_req && |w_hit;
    assign w_wb_done  = !rst && r_state == L2_WRITEBACK && i_pmem_resp;
    assign w_fill     = !rst && r_state == L2_ALLOCATE && i_pmem_resp;
    l2_plru u_plru (
        .i_lru      (i_lru),
        .i_way      (w_hit_way),
        .o_victim   (w_victim),
        .o_lru_next (w_lru_next)
    );
    always_comb begin
        for (int i = 0; i < 4; i++) w_way_ctl[i] = '0;
        if (w_hit_resp && i_mem_write) w_way_ctl[w_hit_way] = '{load_d: 1'b1, load_v: 1'b0, load_TD: 1'b1, d_in: 1'b1, v_in: 1'b0};
        if (w_wb_done) w_way_ctl[r_victim] = '{load_d: 1'b1, load_v: 1'b0, load_TD: 1'b0, d_in: 1'b0, v_in: 1'b0};
        if (w_fill) w_way_ctl[r_victim] = '{load_d: 1'b1, load_v: 1'b1, load_TD: 1'b1, d_in: 1'b0, v_in: 1'b1};
    end
    assign o_ctl        = '{load_lru: w_hit_resp, way3: w_way_ctl[3], way2: w_way_ctl[2], way1: w_way_ctl[1], way0: w_way_ctl[0]};
    assign o_mem_resp   = w_hit_resp;
    assign o_lru_out    = w_hit_resp ? w_lru_next : '0;
    assign o_way_sel    = w_hit_resp ? w_hit_way : (r_state == L2_IDLE ? 2'd0 : r_victim);
    assign o_addr_sel   = r_state == L2_WRITEBACK;
    assign o_datain_sel = w_hit_resp && i_mem_write;
    assign o_pmem_read  = r_pmem_read;
    assign o_pmem_write = r_pmem_write;
    // victim is latched at the miss decision and never re-evaluated until the line is filled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= L2_IDLE;
            r_victim     <= 2'd0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_state)
                L2_IDLE: if (w_req && !(|w_hit)) begin
                    r_victim     <= w_victim;
                    r_state      <= w_dirty[w_victim] ? L2_WRITEBACK : L2_ALLOCATE;
                    r_pmem_write <= w_dirty[w_victim];
                    r_pmem_read  <= !w_dirty[w_victim];
                end
                L2_WRITEBACK: if (i_pmem_resp) begin
                    r_state      <= L2_ALLOCATE;
                    r_pmem_write <= 1'b0;
                    r_pmem_read  <= 1'b1;
                end
                L2_ALLOCATE: if (i_pmem_resp) begin
                    r_state     <= L2_IDLE;
                    r_pmem_read <= 1'b0;
                end
                default: begin
                    r_state      <= L2_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule
